// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control unit of the multicycle RV32I core (lw, sw, R-type, I-type ALU,
// beq, jal). It has three parts:
//   * a Moore main FSM that sequences each instruction through its steps,
//   * an ALU decoder that turns the FSM's alu_op and funct fields into an ALU
//     operation,
//   * an immediate-type decoder that works from the opcode alone.
// The state register is the only storage. The opcode is not latched here,
// because the IR holds it stable from the end of FETCH onwards.
//
// Parameters
//   STATE_W    width of the state register and of state_o (must be >= 4)
//   ALUCTRL_W  width of alu_control. The encodings use the low 3 bits and the
//              upper bits are 0.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high; forces state to FETCH at once
//   op           in   instr[6:0]
//   funct3       in   instr[14:12]
//   funct7b5     in   instr[30]
//   zero         in   ALU result == 0 (combinational from the datapath)
//   pc_write     out  PC register enable
//   ir_write     out  IR / OldPC register enable
//   reg_write    out  register-file write enable
//   mem_write    out  data memory write enable
//   adr_src      out  0: memory address = PC, 1: memory address = Result
//   result_src   out  00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a    out  00 PC, 01 OldPC, 10 rs1 (A register)
//   alu_src_b    out  00 rs2 (WriteData register), 01 ImmExt, 10 constant 4
//   imm_src      out  00 I, 01 S, 10 B, 11 J
//   alu_control  out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   state_o      out  current state code (debug / verification only)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int STATE_W   = 4,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [STATE_W-1:0]   state_o
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // The state register is a plain vector rather than the enum type. Codes
  // 11 and above must be representable so that they can be recovered from.
  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;

  // Raw FSM outputs, before the reset masking of the write enables.
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    case (state_reg)
      FETCH: begin
        // Read the instruction at PC and compute PC + 4 in the same cycle.
        ir_write_raw = 1'b1;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
        state_next   = DECODE;
      end
      DECODE: begin
        // The branch/jump target OldPC + imm is precomputed here. It is used
        // by beq, which compares operands while ALUOut holds the target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECR;
          OP_ITYPE:     state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = FETCH;  // illegal op is dropped
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        result_src = 2'b00;
        adr_src    = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      MEMWRITE: begin
        result_src    = 2'b00;
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        result_src    = 2'b00;
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      BEQ: begin
        // The ALU subtracts rs1 - rs2 and the target is taken from ALUOut.
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        // The PC takes the target from ALUOut while the ALU forms OldPC + 4
        // as the link value. ALUWB then writes that link value to rd.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = 2'b00;
        result_src = 2'b00;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: begin
        // Unused codes: every output stays 0 and the FSM recovers to FETCH.
        state_next = FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write enables
  // ---------------------------------------------------------------------------
  // Reset already shows the FETCH outputs because the state clears at once.
  // Only the enables that change architectural state are masked, so that an
  // aborted instruction cannot write anything.
  assign pc_write  = (pc_update | (branch & zero)) & ~reset;
  assign ir_write  = ir_write_raw  & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign mem_write = mem_write_raw & ~reset;

  // ---------------------------------------------------------------------------
  // ALU decoder
  // ---------------------------------------------------------------------------
  // Subtract applies only to the register form (op[5] = 1). addi with
  // instr[30] set is still an add.
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctl = ALU_SLT;
          3'b110:  alu_ctl = ALU_OR;
          3'b111:  alu_ctl = ALU_AND;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  assign alu_control = ALUCTRL_W'(alu_ctl);

  // ---------------------------------------------------------------------------
  // Immediate-type decoder (valid in every state)
  // ---------------------------------------------------------------------------
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_LW, OP_ITYPE: imm_src = 2'b00;
      OP_SW:           imm_src = 2'b01;
      OP_BEQ:          imm_src = 2'b10;
      OP_JAL:          imm_src = 2'b11;
      default:         imm_src = 2'b00;
    endcase
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. A single linear sequence of steps
// drives the opcode and funct fields. The expected state codes and control
// values at each point are written out by hand.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller #(
    .STATE_W   (4),
    .ALUCTRL_W (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    op       = 7'b0000000;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    #1;

    // ---- reset: FETCH values shown, write enables masked
    chk("rst_state", state_o, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_src_b", alu_src_b, 2'b10);
    chk("rst_result_src", result_src, 2'b10);
    $display("txn reset: state=%0d", state_o);
    tick();
    chk("rst_hold_state", state_o, 0);

    // ---- lw: 0,1,2,3,4,0
    @(negedge clk);
    op    = 7'b0000011;
    reset = 1'b0;
    #1;
    chk("lw_fetch_irw", ir_write, 1);
    chk("lw_fetch_pcw", pc_write, 1);
    chk("lw_fetch_adr", adr_src, 0);
    tick(); chk("lw_s1", state_o, 1);
    chk("lw_dec_src_a", alu_src_a, 2'b01);
    chk("lw_dec_src_b", alu_src_b, 2'b01);
    chk("lw_imm", imm_src, 2'b00);
    tick(); chk("lw_s2", state_o, 2);
    chk("lw_madr_src_a", alu_src_a, 2'b10);
    chk("lw_madr_regw", reg_write, 0);
    tick(); chk("lw_s3", state_o, 3);
    chk("lw_mread_adr", adr_src, 1);
    chk("lw_mread_regw", reg_write, 0);
    tick(); chk("lw_s4", state_o, 4);
    chk("lw_mwb_regw", reg_write, 1);
    chk("lw_mwb_res", result_src, 2'b01);
    tick(); chk("lw_s0", state_o, 0);
    $display("txn lw: done");

    // ---- sw: 0,1,2,5,0
    op = 7'b0100011;
    #1;
    chk("sw_imm", imm_src, 2'b01);
    tick(); chk("sw_s1", state_o, 1);
    tick(); chk("sw_s2", state_o, 2);
    chk("sw_madr_memw", mem_write, 0);
    tick(); chk("sw_s5", state_o, 5);
    chk("sw_memw", mem_write, 1);
    chk("sw_regw", reg_write, 0);
    chk("sw_adr", adr_src, 1);
    tick(); chk("sw_s0", state_o, 0);
    chk("sw_after_memw", mem_write, 0);
    $display("txn sw: done");

    // ---- R-type sub plus other funct3 decodes while in EXECR
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); chk("r_s1", state_o, 1);
    tick(); chk("r_s6", state_o, 6);
    chk("r_sub_ctl", alu_control, 3'b001);
    chk("r_src_a", alu_src_a, 2'b10);
    chk("r_src_b", alu_src_b, 2'b00);
    funct3 = 3'b111; #1; chk("r_and_ctl", alu_control, 3'b010);
    funct3 = 3'b110; #1; chk("r_or_ctl", alu_control, 3'b011);
    funct3 = 3'b010; #1; chk("r_slt_ctl", alu_control, 3'b101);
    funct3 = 3'b000; funct7b5 = 1'b0; #1; chk("r_add_ctl", alu_control, 3'b000);
    tick(); chk("r_s8", state_o, 8);
    chk("r_wb_regw", reg_write, 1);
    tick(); chk("r_s0", state_o, 0);
    $display("txn rtype: done");

    // ---- addi with instr[30]=1 stays add
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); chk("i_s1", state_o, 1);
    tick(); chk("i_s7", state_o, 7);
    chk("i_addi_ctl", alu_control, 3'b000);
    chk("i_src_b", alu_src_b, 2'b01);
    tick(); chk("i_s8", state_o, 8);
    tick(); chk("i_s0", state_o, 0);
    $display("txn addi: done");

    // ---- beq: pc_write follows zero in BEQ
    op = 7'b1100011; funct7b5 = 1'b0; zero = 1'b1;
    tick(); chk("beq_s1", state_o, 1);
    chk("beq_imm", imm_src, 2'b10);
    chk("beq_dec_pcw", pc_write, 0);
    tick(); chk("beq_s9", state_o, 9);
    chk("beq_taken_pcw", pc_write, 1);
    chk("beq_ctl", alu_control, 3'b001);
    zero = 1'b0; #1;
    chk("beq_nottaken_pcw", pc_write, 0);
    tick(); chk("beq_s0", state_o, 0);
    $display("txn beq: done");

    // ---- jal: 0,1,10,8,0
    op = 7'b1101111;
    tick(); chk("jal_s1", state_o, 1);
    chk("jal_imm", imm_src, 2'b11);
    tick(); chk("jal_s10", state_o, 10);
    chk("jal_pcw", pc_write, 1);
    chk("jal_src_a", alu_src_a, 2'b01);
    chk("jal_src_b", alu_src_b, 2'b10);
    tick(); chk("jal_s8", state_o, 8);
    chk("jal_wb_pcw", pc_write, 0);
    tick(); chk("jal_s0", state_o, 0);
    $display("txn jal: done");

    // ---- illegal op: DECODE then straight back to FETCH
    op = 7'b0000000;
    tick(); chk("ill_s1", state_o, 1);
    chk("ill_enables", {pc_write, ir_write, reg_write, mem_write}, 4'b0000);
    tick(); chk("ill_s0", state_o, 0);
    $display("txn illegal: done");

    // ---- reset in the middle of MEMWB
    op = 7'b0000011;
    tick(); tick(); tick(); tick();
    chk("rmid_s4", state_o, 4);
    chk("rmid_regw_pre", reg_write, 1);
    reset = 1'b1;
    #1;
    chk("rmid_state", state_o, 0);
    chk("rmid_regw", reg_write, 0);
    chk("rmid_irw", ir_write, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmid_rel_s0", state_o, 0);
    tick(); chk("rmid_rel_s1", state_o, 1);
    tick(); chk("rmid_rel_s2", state_o, 2);
    tick(); tick(); tick(); chk("rmid_done_s0", state_o, 0);
    $display("txn reset_mid: done");

    // ---- unused state code 13: outputs 0, next FETCH
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    tick(); tick(); tick();
    chk("bad_pre_s8", state_o, 8);
    force dut.state_reg = 4'd13;
    #1;
    chk("bad_state", state_o, 13);
    chk("bad_enables", {pc_write, ir_write, reg_write, mem_write}, 4'b0000);
    chk("bad_sels", {adr_src, result_src, alu_src_a, alu_src_b}, 7'b0000000);
    release dut.state_reg;
    tick(); chk("bad_next_s0", state_o, 0);
    $display("txn bad_state: done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
